// File: rtl/ctrl_ex.sv
// Execute-stage control for the 16-bit Thumb-subset pipeline.
//
// Sequences multi-cycle LDR/STR accesses with a countdown FSM, back-pressures
// fetch/decode through o_stall, resolves B conditions against the registered
// flags and drives the registered register-file write-back controls.
//
// Build option: CTRL_EX_COND_BRANCH_EN enables full condition-code evaluation.
// Without it only cond 1110 (always) is taken.
//
// Ports:
//   clk               clock, rising edge
//   rst               synchronous active-high reset
//   i_ir_ex           instruction in EX (held stable while o_stall=1)
//   i_mem_data_access LDR/STR access length in cycles (0 otherwise)
//   i_alu_nzcv        combinational ALU flags {N,Z,C,V}
//   o_stall           freeze fetch/decode (combinational)
//   o_mem_re          read strobe, first LDR cycle (combinational)
//   o_mem_we          write strobe, first STR cycle (combinational)
//   o_branch_taken    B in EX is taken (combinational)
//   o_rf_we_r         registered register-file write enable
//   o_rf_waddr_r      registered register-file write index
//   o_flags_r         architectural {N,Z,C,V}
module ctrl_ex #(
  parameter int unsigned SP_ADDR = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_ir_ex,
  input  logic [3:0]  i_mem_data_access,
  input  logic [3:0]  i_alu_nzcv,
  output logic        o_stall,
  output logic        o_mem_re,
  output logic        o_mem_we,
  output logic        o_branch_taken,
  output logic        o_rf_we_r,
  output logic [3:0]  o_rf_waddr_r,
  output logic [3:0]  o_flags_r
);

  localparam logic [3:0] SpAddr = 4'(SP_ADDR);

  typedef enum logic {StIdle, StMem} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ldr_q, ldr_d;
  logic [2:0] rt_q, rt_d;
  logic       rf_we_q, rf_we_d;
  logic [3:0] rf_waddr_q, rf_waddr_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] flag_mask;

  // Instruction decode
  logic is_add, is_movi, is_cmp, is_movr, is_subsp, is_ldr, is_str, is_b, is_mem;
  logic [3:0] cond;

  assign is_add   = (i_ir_ex[15:9] == 7'b0001110);
  assign is_movi  = (i_ir_ex[15:11] == 5'b00100);
  assign is_cmp   = (i_ir_ex[15:11] == 5'b00101);
  assign is_movr  = (i_ir_ex[15:8] == 8'b01000110);
  assign is_subsp = (i_ir_ex[15:7] == 9'b101100001);
  assign is_ldr   = (i_ir_ex[15:11] == 5'b01101);
  assign is_str   = (i_ir_ex[15:11] == 5'b01100);
  assign is_b     = (i_ir_ex[15:12] == 4'b1101);
  assign is_mem   = is_ldr | is_str;
  assign cond     = i_ir_ex[11:8];

  // Operand fields not consumed by any supported encoding
  logic unused_ir;
  assign unused_ir = ^i_ir_ex[6:3];

  // Branch resolution against the registered flags
  logic cond_pass;
`ifdef CTRL_EX_COND_BRANCH_EN
  logic fl_n, fl_z, fl_c, fl_v;
  assign {fl_n, fl_z, fl_c, fl_v} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    unique case (cond)
      4'b0000: cond_pass = fl_z;
      4'b0001: cond_pass = ~fl_z;
      4'b0010: cond_pass = fl_c;
      4'b0011: cond_pass = ~fl_c;
      4'b0100: cond_pass = fl_n;
      4'b0101: cond_pass = ~fl_n;
      4'b0110: cond_pass = fl_v;
      4'b0111: cond_pass = ~fl_v;
      4'b1000: cond_pass = fl_c & ~fl_z;
      4'b1001: cond_pass = ~fl_c | fl_z;
      4'b1010: cond_pass = (fl_n == fl_v);
      4'b1011: cond_pass = (fl_n != fl_v);
      4'b1100: cond_pass = ~fl_z & (fl_n == fl_v);
      4'b1101: cond_pass = fl_z | (fl_n != fl_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  assign cond_pass = (cond == 4'b1110);
`endif

  assign o_branch_taken = is_b & cond_pass;

  // FSM next-state, strobes and completion-cycle effects
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ldr_d      = ldr_q;
    rt_d       = rt_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    flag_mask  = 4'b0000;
    o_stall    = 1'b0;
    o_mem_re   = 1'b0;
    o_mem_we   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          o_mem_re = is_ldr;
          o_mem_we = is_str;
          if (i_mem_data_access >= 4'd2) begin
            // Latch the access so later input changes cannot disturb it
            o_stall = 1'b1;
            cnt_d   = i_mem_data_access - 4'd1;
            ldr_d   = is_ldr;
            rt_d    = i_ir_ex[2:0];
            state_d = StMem;
          end else if (is_ldr) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = {1'b0, i_ir_ex[2:0]};
          end
        end else if (is_add) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = {1'b0, i_ir_ex[2:0]};
          flag_mask  = 4'b1111;
        end else if (is_movi) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = {1'b0, i_ir_ex[10:8]};
          flag_mask  = 4'b1100;
        end else if (is_cmp) begin
          flag_mask = 4'b1111;
        end else if (is_movr) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = {i_ir_ex[7], i_ir_ex[2:0]};
        end else if (is_subsp) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = SpAddr;
        end
      end
      StMem: begin
        o_stall = (cnt_q != 4'd1);
        cnt_d   = cnt_q - 4'd1;
        // cnt_q==0 cannot occur; treat it as completion so the FSM never wraps
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = StIdle;
          if (ldr_q) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = {1'b0, rt_q};
          end
        end
      end
      default: state_d = StIdle;
    endcase

    flags_d = (flags_q & ~flag_mask) | (i_alu_nzcv & flag_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      ldr_q      <= 1'b0;
      rt_q       <= 3'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 4'd0;
      flags_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ldr_q      <= ldr_d;
      rt_q       <= rt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      flags_q    <= flags_d;
    end
  end

  assign o_rf_we_r    = rf_we_q;
  assign o_rf_waddr_r = rf_waddr_q;
  assign o_flags_r    = flags_q;

endmodule

// File: tb/tb_ctrl_ex.sv
module tb_ctrl_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_ir_ex;
  logic [3:0]  i_mem_data_access;
  logic [3:0]  i_alu_nzcv;
  logic        o_stall, o_mem_re, o_mem_we, o_branch_taken, o_rf_we_r;
  logic [3:0]  o_rf_waddr_r, o_flags_r;

  always #5 clk = ~clk;

  ctrl_ex #(.SP_ADDR(13)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_ir_ex          (i_ir_ex),
    .i_mem_data_access(i_mem_data_access),
    .i_alu_nzcv       (i_alu_nzcv),
    .o_stall          (o_stall),
    .o_mem_re         (o_mem_re),
    .o_mem_we         (o_mem_we),
    .o_branch_taken   (o_branch_taken),
    .o_rf_we_r        (o_rf_we_r),
    .o_rf_waddr_r     (o_rf_waddr_r),
    .o_flags_r        (o_flags_r)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int KNop = 0, KAdd = 1, KMovi = 2, KCmp = 3, KMovr = 4, KSubsp = 5,
                 KLdr = 6, KStr = 7, KB = 8;

  function automatic int kind_of(input logic [15:0] ir);
    if (ir[15:9] == 7'b0001110) return KAdd;
    if (ir[15:11] == 5'b00100) return KMovi;
    if (ir[15:11] == 5'b00101) return KCmp;
    if (ir[15:8] == 8'h46) return KMovr;
    if (ir[15:7] == 9'b101100001) return KSubsp;
    if (ir[15:11] == 5'b01101) return KLdr;
    if (ir[15:11] == 5'b01100) return KStr;
    if (ir[15:12] == 4'b1101) return KB;
    return KNop;
  endfunction

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
`ifdef CTRL_EX_COND_BRANCH_EN
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (c == 4'd14) && (n | z | cf | v | 1'b1);
`endif
  endfunction

  // Write-back and flag effects of a completed instruction
  task automatic effects(input logic [15:0] ir, output logic we, output logic [3:0] wa,
                         output logic [3:0] mask);
    int k;
    k = kind_of(ir);
    we = 1'b0; wa = 4'd0; mask = 4'b0000;
    case (k)
      KAdd:   begin we = 1'b1; wa = {1'b0, ir[2:0]}; mask = 4'b1111; end
      KMovi:  begin we = 1'b1; wa = {1'b0, ir[10:8]}; mask = 4'b1100; end
      KCmp:   mask = 4'b1111;
      KMovr:  begin we = 1'b1; wa = {ir[7], ir[2:0]}; end
      KSubsp: begin we = 1'b1; wa = 4'd13; end
      KLdr:   begin we = 1'b1; wa = {1'b0, ir[2:0]}; end
      default: ;
    endcase
  endtask

  function automatic logic [15:0] gen_ir();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 8))
      0: return {7'b0001110, r[8:0]};
      1: return {5'b00100, r[10:0]};
      2: return {5'b00101, r[10:0]};
      3: return {8'h46, r[7:0]};
      4: return {9'b101100001, r[6:0]};
      5: return {5'b01101, r[10:0]};
      6: return {5'b01100, r[10:0]};
      7: return {4'b1101, r[11:0]};
      default: return r;
    endcase
  endfunction

  task automatic drive(input logic [15:0] ir, input logic [3:0] n, input logic [3:0] nzcv);
    @(negedge clk);
    i_ir_ex = ir;
    i_mem_data_access = n;
    i_alu_nzcv = nzcv;
    #1;
  endtask

  task automatic to_reg_sample();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0] ir;
    logic [3:0]  nzcv;
    logic        br_en;   // branch taken with full condition evaluation
    logic        br_dis;  // branch taken with only AL supported
    logic        we;
    logic [3:0]  waddr;
    logic [3:0]  flags;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [3:0] m_flags;
    logic exp_br, ewe;
    logic [3:0] ewa, emask;

    tbl[0]  = '{16'h2305, 4'b0110, 1'b0, 1'b0, 1'b1, 4'd3,  4'b0100};
    tbl[1]  = '{16'h46EB, 4'b1111, 1'b0, 1'b0, 1'b1, 4'd11, 4'b0100};
    tbl[2]  = '{16'hB081, 4'b1111, 1'b0, 1'b0, 1'b1, 4'd13, 4'b0100};
    tbl[3]  = '{16'h1C8A, 4'b1011, 1'b0, 1'b0, 1'b1, 4'd2,  4'b1011};
    tbl[4]  = '{16'h2A07, 4'b0100, 1'b0, 1'b0, 1'b0, 4'd0,  4'b0100};
    tbl[5]  = '{16'hD005, 4'b1111, 1'b1, 1'b0, 1'b0, 4'd0,  4'b0100};
    tbl[6]  = '{16'hDE00, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd0,  4'b0100};
    tbl[7]  = '{16'hDF00, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd0,  4'b0100};
    tbl[8]  = '{16'h0000, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd0,  4'b0100};
    tbl[9]  = '{16'h2A07, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0,  4'b0000};
    tbl[10] = '{16'hD005, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd0,  4'b0000};
    tbl[11] = '{16'hD105, 4'b1111, 1'b1, 1'b0, 1'b0, 4'd0,  4'b0000};
    tbl[12] = '{16'h2A07, 4'b1001, 1'b0, 1'b0, 1'b0, 4'd0,  4'b1001};
    tbl[13] = '{16'hDA00, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0,  4'b1001};
    tbl[14] = '{16'hDB00, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0,  4'b1001};
    tbl[15] = '{16'h2A07, 4'b0010, 1'b0, 1'b0, 1'b0, 4'd0,  4'b0010};
    tbl[16] = '{16'hD800, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0,  4'b0010};
    tbl[17] = '{16'hD900, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0,  4'b0010};
    tbl[18] = '{16'h2000, 4'b1011, 1'b0, 1'b0, 1'b1, 4'd0,  4'b1010};
    tbl[19] = '{16'hDC00, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0,  4'b1010};
    tbl[20] = '{16'hDD00, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0,  4'b1010};

    // Reset
    rst = 1'b1;
    i_ir_ex = 16'h0000;
    i_mem_data_access = 4'd0;
    i_alu_nzcv = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("reset_rf_we", o_rf_we_r, 1'b0);
    chk4("reset_waddr", o_rf_waddr_r, 4'd0);
    chk4("reset_flags", o_flags_r, 4'd0);
    chk1("reset_stall", o_stall, 1'b0);
    chk1("reset_re", o_mem_re, 1'b0);
    chk1("reset_we", o_mem_we, 1'b0);
    chk1("reset_br", o_branch_taken, 1'b0);

    // Single-cycle instruction table
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].ir, 4'd0, tbl[i].nzcv);
`ifdef CTRL_EX_COND_BRANCH_EN
      exp_br = tbl[i].br_en;
`else
      exp_br = tbl[i].br_dis;
`endif
      chk1($sformatf("tbl%0d_stall", i), o_stall, 1'b0);
      chk1($sformatf("tbl%0d_re", i), o_mem_re, 1'b0);
      chk1($sformatf("tbl%0d_we", i), o_mem_we, 1'b0);
      chk1($sformatf("tbl%0d_br", i), o_branch_taken, exp_br);
      to_reg_sample();
      chk1($sformatf("tbl%0d_rf_we", i), o_rf_we_r, tbl[i].we);
      if (tbl[i].we) chk4($sformatf("tbl%0d_waddr", i), o_rf_waddr_r, tbl[i].waddr);
      chk4($sformatf("tbl%0d_flags", i), o_flags_r, tbl[i].flags);
    end
    m_flags = tbl[20].flags;

    // LDR R0 with N=3; length input changes mid-access and must be ignored
    drive(16'h6808, 4'd3, 4'b1111);
    chk1("ldr3_c0_re", o_mem_re, 1'b1);
    chk1("ldr3_c0_stall", o_stall, 1'b1);
    to_reg_sample();
    chk1("ldr3_c0_rf_we", o_rf_we_r, 1'b0);
    drive(16'h6808, 4'd9, 4'b1111);
    chk1("ldr3_c1_re", o_mem_re, 1'b0);
    chk1("ldr3_c1_stall", o_stall, 1'b1);
    to_reg_sample();
    chk1("ldr3_c1_rf_we", o_rf_we_r, 1'b0);
    drive(16'h6808, 4'd9, 4'b1111);
    chk1("ldr3_c2_stall", o_stall, 1'b0);
    chk1("ldr3_c2_re", o_mem_re, 1'b0);
    to_reg_sample();
    chk1("ldr3_c3_rf_we", o_rf_we_r, 1'b1);
    chk4("ldr3_c3_waddr", o_rf_waddr_r, 4'd0);
    chk4("ldr3_flags", o_flags_r, m_flags);
    drive(16'h0000, 4'd0, 4'b0000);
    to_reg_sample();
    chk1("ldr3_c4_rf_we", o_rf_we_r, 1'b0);

    // STR with N=1 and N=0: single strobe, no stall, no write-back
    for (int n = 1; n >= 0; n--) begin
      drive(16'h6000, 4'(n), 4'b1111);
      chk1($sformatf("str%0d_we", n), o_mem_we, 1'b1);
      chk1($sformatf("str%0d_stall", n), o_stall, 1'b0);
      to_reg_sample();
      chk1($sformatf("str%0d_rf_we", n), o_rf_we_r, 1'b0);
      drive(16'h0000, 4'd0, 4'b0000);
      chk1($sformatf("str%0d_we_off", n), o_mem_we, 1'b0);
      to_reg_sample();
    end

    // LDR R5 with N=4, reset in the second stall cycle
    drive(16'h680D, 4'd4, 4'b1111);
    chk1("ldrrst_c0_stall", o_stall, 1'b1);
    to_reg_sample();
    drive(16'h680D, 4'd4, 4'b1111);
    rst = 1'b1;
    chk1("ldrrst_c1_stall", o_stall, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    i_ir_ex = 16'h0000;
    i_mem_data_access = 4'd0;
    #1;
    chk1("ldrrst_stall", o_stall, 1'b0);
    chk1("ldrrst_rf_we", o_rf_we_r, 1'b0);
    chk4("ldrrst_flags", o_flags_r, 4'd0);
    for (int i = 0; i < 4; i++) begin
      to_reg_sample();
      chk1($sformatf("ldrrst_post%0d_rf_we", i), o_rf_we_r, 1'b0);
      chk1($sformatf("ldrrst_post%0d_stall", i), o_stall, 1'b0);
    end
    m_flags = 4'd0;

    // Randomized instruction stream against the model
    for (int k = 0; k < 300; k++) begin
      logic [15:0] ir;
      logic [3:0] n;
      int kd, cycles;
      ir = gen_ir();
      kd = kind_of(ir);
      n = (kd == KLdr || kd == KStr) ? 4'($urandom) : 4'd0;
      cycles = ((kd == KLdr || kd == KStr) && n >= 4'd2) ? int'(n) : 1;
      for (int c = 0; c < cycles; c++) begin
        drive(ir, (c == 0) ? n : 4'($urandom), 4'($urandom));
        chk1("rnd_stall", o_stall, c != cycles - 1);
        chk1("rnd_re", o_mem_re, kd == KLdr && c == 0);
        chk1("rnd_we", o_mem_we, kd == KStr && c == 0);
        chk1("rnd_br", o_branch_taken, kd == KB && cond_pass(ir[11:8], m_flags));
        ewe = 1'b0; ewa = 4'd0; emask = 4'd0;
        if (c == cycles - 1) effects(ir, ewe, ewa, emask);
        m_flags = (m_flags & ~emask) | (i_alu_nzcv & emask);
        to_reg_sample();
        chk1("rnd_rf_we", o_rf_we_r, ewe);
        if (ewe) chk4("rnd_waddr", o_rf_waddr_r, ewa);
        chk4("rnd_flags", o_flags_r, m_flags);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
